// File: rtl/adder_operand_loader.sv
// adder_operand_loader
//
// Upstream feeder for a registered wide adder stage. It collects operand A and
// then operand B as N = W/BW narrow beats, least-significant chunk first. It then
// presents {a, b, cin} as a held, registered operation behind a valid/ready
// handshake.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   beat present on in_data
//   in_ready   loader accepts a beat this cycle (forced low while rst_n = 0)
//   in_data    BW-bit operand chunk
//   in_cin     carry-in, sampled only with the final B beat
//   a, b       assembled W-bit operands
//   cin        assembled carry-in
//   out_valid  a/b/cin form a complete operation
//   out_ready  downstream accepts the operation
//   op_count   completed output handshakes, wraps modulo 2^CW
module adder_operand_loader #(
  parameter int unsigned W  = 256,
  parameter int unsigned BW = 32,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] in_data,
  input  logic          in_cin,
  output logic [W-1:0]  a,
  output logic [W-1:0]  b,
  output logic          cin,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] op_count
);

  localparam int unsigned N    = W / BW;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  localparam logic [1:0] StLoadA   = 2'd0;
  localparam logic [1:0] StLoadB   = 2'd1;
  localparam logic [1:0] StPresent = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            cin_q, cin_d;
  logic [CW-1:0]   op_count_q, op_count_d;

  logic beat_acc;
  logic last_beat;

  // in_ready is decoded from state but also gated by rst_n so no beat is
  // offered as accepted while the loader is being cleared.
  assign in_ready  = rst_n && ((state_q == StLoadA) || (state_q == StLoadB));
  assign out_valid = (state_q == StPresent);
  assign a         = a_q;
  assign b         = b_q;
  assign cin       = cin_q;
  assign op_count  = op_count_q;

  assign beat_acc  = in_valid && in_ready;
  assign last_beat = (cnt_q == CntLast);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    op_count_d = op_count_q;

    case (state_q)
      StLoadA: begin
        if (beat_acc) begin
          a_d[cnt_q*BW +: BW] = in_data;
          if (last_beat) begin
            cnt_d   = '0;
            state_d = StLoadB;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StLoadB: begin
        if (beat_acc) begin
          b_d[cnt_q*BW +: BW] = in_data;
          if (last_beat) begin
            // Carry-in travels with the final B chunk only.
            cin_d   = in_cin;
            cnt_d   = '0;
            state_d = StPresent;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StPresent: begin
        // Operands stay frozen here; only the handshake moves us on.
        if (out_ready) begin
          op_count_d = op_count_q + CW'(1);
          state_d    = StLoadA;
        end
      end
      default: begin
        // Unreachable encoding: recover to the start of a fresh load.
        cnt_d   = '0;
        state_d = StLoadA;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StLoadA;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cin_q      <= cin_d;
      op_count_q <= op_count_d;
    end
  end

endmodule

// File: tb/tb_adder_operand_loader.sv
// Self-checking bench for adder_operand_loader. Two instances share every
// input: one with the default 16-bit counter and one with a 4-bit counter for
// wrap checks. A beat-index reference model predicts every output each cycle;
// a table of operations plus hand-written sequences covers the corner cases.
module tb_adder_operand_loader;

  localparam int unsigned W   = 256;
  localparam int unsigned BW  = 32;
  localparam int unsigned N   = W / BW;
  localparam int unsigned CW  = 16;
  localparam int unsigned CWS = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [BW-1:0] in_data = '0;
  logic          in_cin = 1'b0;
  logic          out_ready = 1'b0;

  logic           in_ready, cin, out_valid;
  logic [W-1:0]   a, b;
  logic [CW-1:0]  op_count;
  logic           s_in_ready, s_cin, s_out_valid;
  logic [W-1:0]   s_a, s_b;
  logic [CWS-1:0] s_op_count;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  adder_operand_loader #(.W(W), .BW(BW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_cin(in_cin), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .op_count(op_count)
  );

  adder_operand_loader #(.W(W), .BW(BW), .CW(CWS)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_cin(in_cin), .a(s_a), .b(s_b), .cin(s_cin),
    .out_valid(s_out_valid), .out_ready(out_ready), .op_count(s_op_count)
  );

  // Reference model: one running beat index over the whole 2N-beat operation
  // plus a "presenting" flag; the operation count is an unbounded integer.
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  logic         m_cin = 1'b0;
  logic         m_pres = 1'b0;
  int unsigned  m_k = 0;
  int unsigned  m_ops = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_a <= '0; m_b <= '0; m_cin <= 1'b0; m_pres <= 1'b0; m_k <= 0; m_ops <= 0;
    end else if (m_pres) begin
      if (out_ready) begin
        m_pres <= 1'b0;
        m_ops  <= m_ops + 1;
      end
    end else if (in_valid) begin
      if (m_k < N) m_a[m_k*BW +: BW] <= in_data;
      else         m_b[(m_k-N)*BW +: BW] <= in_data;
      if (m_k == 2*N-1) begin
        m_cin  <= in_cin;
        m_pres <= 1'b1;
        m_k    <= 0;
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check_all();
    chk("in_ready", W'(in_ready), W'(rst_n && !m_pres));
    chk("out_valid", W'(out_valid), W'(m_pres));
    chk("a", a, m_a);
    chk("b", b, m_b);
    chk("cin", W'(cin), W'(m_cin));
    chk("op_count", W'(op_count), W'(m_ops % 65536));
    chk("s_out_valid", W'(s_out_valid), W'(m_pres));
    chk("s_op_count", W'(s_op_count), W'(m_ops % 16));
  endtask

  // Drive one cycle of inputs, let the edge pass, check on the falling edge.
  task automatic step(input bit v, input logic [BW-1:0] d, input bit c, input bit r);
    in_valid  = v;
    in_data   = d;
    in_cin    = c;
    out_ready = r;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic send_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit c,
                         input bit cin_other, input int gap);
    logic [BW-1:0] d;
    for (int i = 0; i < 2*N; i++) begin
      while (gap > 0 && $urandom_range(99) < gap)
        step(1'b0, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
      d = (i < N) ? av[i*BW +: BW] : bv[(i-N)*BW +: BW];
      step(1'b1, d, (i == 2*N-1) ? c : cin_other, 1'($urandom_range(1)));
    end
  endtask

  task automatic send_gen(input logic [BW-1:0] a0, input logic [BW-1:0] as,
                          input logic [BW-1:0] b0, input logic [BW-1:0] bs,
                          input bit c, input bit cin_other, input int gap);
    logic [W-1:0] av, bv;
    for (int i = 0; i < N; i++) begin
      av[i*BW +: BW] = a0 + BW'(i) * as;
      bv[i*BW +: BW] = b0 + BW'(i) * bs;
    end
    send_op(av, bv, c, cin_other, gap);
  endtask

  task automatic wait_present(input string name);
    int k = 0;
    while (!out_valid && k < 4) begin
      step(1'b0, '0, 1'b0, 1'b0);
      k++;
    end
    chk(name, W'(out_valid), W'(1));
  endtask

  task automatic handshake();
    step(1'b0, $urandom, 1'b0, 1'b1);
    chk("hs_out_valid", W'(out_valid), W'(0));
    chk("hs_in_ready", W'(in_ready), W'(1));
  endtask

  typedef struct {
    logic [BW-1:0] a0, as, b0, bs;
    bit            c;
    logic [W-1:0]  exp_a, exp_b;
  } vec_t;

  localparam logic [W-1:0] BasicA =
    256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001;

  vec_t vecs[3];
  logic [W-1:0] rv_a, rv_b;

  initial begin
    vecs[0] = '{32'h1, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b1, BasicA, {8{32'hFFFFFFFF}}};
    vecs[1] = '{32'h0, 32'h11111111, 32'h80000001, 32'h0, 1'b0,
      256'h77777777_66666666_55555555_44444444_33333333_22222222_11111111_00000000,
      {8{32'h80000001}}};
    vecs[2] = '{32'hFFFFFFFF, 32'h1, 32'h10, 32'h10, 1'b1,
      256'h00000006_00000005_00000004_00000003_00000002_00000001_00000000_FFFFFFFF,
      256'h00000080_00000070_00000060_00000050_00000040_00000030_00000020_00000010};

    // Reset with in_valid held high.
    rst_n = 1'b0;
    step(1'b1, $urandom, 1'b1, 1'b1);
    step(1'b1, $urandom, 1'b1, 1'b1);
    chk("rst_a", a, '0);
    chk("rst_b", b, '0);
    chk("rst_in_ready", W'(in_ready), W'(0));
    chk("rst_op_count", W'(op_count), W'(0));
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rel_in_ready", W'(in_ready), W'(1));

    // Table of whole operations.
    for (int v = 0; v < 3; v++) begin
      send_gen(vecs[v].a0, vecs[v].as, vecs[v].b0, vecs[v].bs, vecs[v].c, 1'b0,
               (v == 0) ? 0 : 30);
      wait_present("tbl_present");
      chk("tbl_a", a, vecs[v].exp_a);
      chk("tbl_b", b, vecs[v].exp_b);
      chk("tbl_cin", W'(cin), W'(vecs[v].c));
      handshake();
      chk("tbl_op_count", W'(op_count), W'(v + 1));
    end

    // Backpressure with junk beats offered while presenting.
    send_gen(32'h1, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, $urandom, 1'($urandom_range(1)), 1'b0);
      chk("bp_a", a, BasicA);
      chk("bp_out_valid", W'(out_valid), W'(1));
      chk("bp_in_ready", W'(in_ready), W'(0));
    end
    handshake();

    // Gapped input; carry-in high on every beat except the last.
    send_gen(32'h1, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b1, 50);
    wait_present("gap_present");
    chk("gap_a", a, BasicA);
    chk("gap_cin", W'(cin), W'(0));
    handshake();

    // Reset after 11 beats, then a fresh operation.
    for (int i = 0; i < 11; i++) step(1'b1, $urandom, 1'b1, 1'b0);
    rst_n = 1'b0;
    step(1'b1, $urandom, 1'b1, 1'b0);
    rst_n = 1'b1;
    send_gen(32'hA5A5A5A5, 32'h0, 32'h5A5A5A5A, 32'h0, 1'b0, 1'b0, 0);
    wait_present("mid_present");
    chk("mid_a", a, {8{32'hA5A5A5A5}});
    chk("mid_b", b, {8{32'h5A5A5A5A}});
    chk("mid_cin", W'(cin), W'(0));
    handshake();

    // Counter wrap on the 4-bit instance.
    rst_n = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      send_gen(BW'($urandom), BW'($urandom), BW'($urandom), BW'($urandom),
               1'($urandom_range(1)), 1'($urandom_range(1)), 0);
      wait_present("wrap_present");
      handshake();
      if (k == 15) chk("wrap15", W'(s_op_count), W'(15));
      if (k == 16) chk("wrap16", W'(s_op_count), W'(0));
      if (k == 17) chk("wrap17", W'(s_op_count), W'(1));
    end

    // Random operations with gaps and random downstream stalls.
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < N; i++) begin
        rv_a[i*BW +: BW] = $urandom;
        rv_b[i*BW +: BW] = $urandom;
      end
      send_op(rv_a, rv_b, 1'($urandom_range(1)), 1'($urandom_range(1)), 30);
      wait_present("rnd_present");
      chk("rnd_a", a, rv_a);
      chk("rnd_b", b, rv_b);
      for (int s = 0; s < int'($urandom_range(3)); s++)
        step(1'($urandom_range(1)), $urandom, 1'($urandom_range(1)), 1'b0);
      handshake();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

endmodule
